// File: rtl/time_uart_reporter_if.sv
// ---------------------------------------------------------------------------
// time_uart_reporter_if
//   Byte-level link between the time reporter and a UART transmitter.
//
//   Handshake semantics: the master asserts tx_start for exactly one cycle
//   with tx_data valid in that same cycle. tx_data is held stable afterwards
//   until the next tx_start. The slave answers with a one-cycle tx_done pulse
//   once the byte has left the line. The master issues no new tx_start until
//   it has seen tx_done for the previous byte.
//
//   Signals:
//     tx_data   [7:0]  byte to transmit           (master -> slave)
//     tx_start         one-cycle start pulse      (master -> slave)
//     tx_done          one-cycle completion pulse (slave -> master)
// ---------------------------------------------------------------------------
interface time_uart_reporter_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_done;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_done
  );
endinterface

// File: rtl/time_uart_reporter.sv
// ---------------------------------------------------------------------------
// time_uart_reporter
//   Snapshots the displayed time and sends it to a byte UART transmitter as a
//   15-byte ASCII frame: tag, ' ', "HH:MM:SS.CC", CR, LF.
//   A frame is requested by a one-cycle i_send pulse, or automatically while
//   i_auto is high whenever i_sec changes. A request that arrives while a
//   frame is in flight is remembered (one deep) and served afterwards.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset
//     i_send     one-cycle report request
//     i_auto     level; enables a report on every change of i_sec
//     i_mode     tag select: 0 = watch (TAG_WATCH), 1 = stopwatch (TAG_STOP)
//     i_msec     centiseconds 0..99 (larger values saturate to 99)
//     i_sec      seconds 0..59      (larger values saturate to 59)
//     i_min      minutes 0..59      (larger values saturate to 59)
//     i_hour     hours 0..23        (larger values saturate to 23)
//     tx         byte link to the UART TX (master side)
//     o_busy     high from frame acceptance until the last tx_done
//     o_done     one-cycle pulse after the LF byte has completed
//     dbg_state  current FSM state (IDLE=0 LOAD=1 SEND=2 WAIT=3 FIN=4)
// ---------------------------------------------------------------------------
module time_uart_reporter #(
  parameter logic [7:0] TAG_WATCH = 8'h57,
  parameter logic [7:0] TAG_STOP  = 8'h53
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_send,
  input  logic                        i_auto,
  input  logic                        i_mode,
  input  logic [6:0]                  i_msec,
  input  logic [5:0]                  i_sec,
  input  logic [5:0]                  i_min,
  input  logic [4:0]                  i_hour,
  time_uart_reporter_if.master        tx,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd14;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic        pending, pending_nx;
  logic        snap_en;
  logic [5:0]  sec_q;
  logic        trigger;

  // Snapshot of the frame contents, already in ASCII.
  logic [7:0]  tag_q;
  logic [15:0] hour_a, min_a, sec_a, msec_a;

  logic [7:0]  tx_data_q;
  logic [7:0]  byte_sel;

  // Saturated inputs, widened to a common width for the digit converter.
  logic [6:0]  msec_sat, sec_sat, min_sat, hour_sat;

  // Two ASCII digits (tens, ones) of a value 0..99.
  function automatic logic [15:0] to_ascii2(input logic [6:0] v);
    logic [6:0] tens;
    logic [6:0] ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, ones}};
  endfunction

  always_comb begin
    msec_sat = (i_msec > 7'd99) ? 7'd99 : i_msec;
    sec_sat  = (i_sec  > 6'd59) ? 7'd59 : {1'b0, i_sec};
    min_sat  = (i_min  > 6'd59) ? 7'd59 : {1'b0, i_min};
    hour_sat = (i_hour > 5'd23) ? 7'd23 : {2'b00, i_hour};
  end

  // Manual request and auto request merge into a single trigger, so both in
  // the same cycle count once.
  assign trigger = i_send | (i_auto & (i_sec != sec_q));

  // Next-state, index and pending logic.
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    pending_nx = pending;
    snap_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger || pending) begin
          state_nx   = S_LOAD;
          snap_en    = 1'b1;
          pending_nx = 1'b0;
        end
      end
      S_LOAD: begin
        idx_nx   = 4'd0;
        state_nx = S_SEND;
        if (trigger) pending_nx = 1'b1;
      end
      S_SEND: begin
        state_nx = S_WAIT;
        if (trigger) pending_nx = 1'b1;
      end
      S_WAIT: begin
        if (tx.tx_done) begin
          if (idx == LAST_IDX) begin
            state_nx = S_FIN;
          end else begin
            idx_nx   = idx + 4'd1;
            state_nx = S_SEND;
          end
        end
        if (trigger) pending_nx = 1'b1;
      end
      S_FIN: begin
        // A trigger landing in FIN is served straight away.
        if (trigger || pending) begin
          state_nx   = S_LOAD;
          snap_en    = 1'b1;
          pending_nx = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Byte for the index about to be sent. The snapshot is taken on entry to
  // LOAD, so it is already valid when LOAD hands over to the first SEND.
  always_comb begin
    byte_sel = 8'h00;
    case (idx_nx)
      4'd0:    byte_sel = tag_q;
      4'd1:    byte_sel = 8'h20;
      4'd2:    byte_sel = hour_a[15:8];
      4'd3:    byte_sel = hour_a[7:0];
      4'd4:    byte_sel = 8'h3A;
      4'd5:    byte_sel = min_a[15:8];
      4'd6:    byte_sel = min_a[7:0];
      4'd7:    byte_sel = 8'h3A;
      4'd8:    byte_sel = sec_a[15:8];
      4'd9:    byte_sel = sec_a[7:0];
      4'd10:   byte_sel = 8'h2E;
      4'd11:   byte_sel = msec_a[15:8];
      4'd12:   byte_sel = msec_a[7:0];
      4'd13:   byte_sel = 8'h0D;
      4'd14:   byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= 4'd0;
      pending <= 1'b0;
      sec_q   <= 6'd0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      pending <= pending_nx;
      sec_q   <= i_sec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q  <= 8'h00;
      hour_a <= 16'h0000;
      min_a  <= 16'h0000;
      sec_a  <= 16'h0000;
      msec_a <= 16'h0000;
    end else if (snap_en) begin
      tag_q  <= i_mode ? TAG_STOP : TAG_WATCH;
      hour_a <= to_ascii2(hour_sat);
      min_a  <= to_ascii2(min_sat);
      sec_a  <= to_ascii2(sec_sat);
      msec_a <= to_ascii2(msec_sat);
    end
  end

  // tx_data changes only when entering SEND and holds in between.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data_q <= 8'h00;
    end else if (state_nx == S_SEND) begin
      tx_data_q <= byte_sel;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_start = (state == S_SEND);
  assign o_busy      = (state == S_LOAD) || (state == S_SEND) || (state == S_WAIT);
  assign o_done      = (state == S_FIN);
  assign dbg_state   = state;

endmodule

// File: tb/tb_time_uart_reporter.sv
module tb_time_uart_reporter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       i_send, i_auto, i_mode;
  logic [6:0] i_msec;
  logic [5:0] i_sec, i_min;
  logic [4:0] i_hour;
  logic       o_busy, o_done;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  time_uart_reporter_if tx();

  time_uart_reporter dut (
    .clk       (clk),
    .reset     (reset),
    .i_send    (i_send),
    .i_auto    (i_auto),
    .i_mode    (i_mode),
    .i_msec    (i_msec),
    .i_sec     (i_sec),
    .i_min     (i_min),
    .i_hour    (i_hour),
    .tx        (tx),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         resp_cnt = 0;
  int         resp_delay = 20;

  typedef struct {
    string        name;
    logic         mode;
    logic [4:0]   hour;
    logic [5:0]   min;
    logic [5:0]   sec;
    logic [6:0]   msec;
    logic         chg_hour;  // move i_hour to 23 one cycle after trigger
    logic [119:0] exp;       // byte 0 in the top 8 bits
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- UART TX model / monitor ----------------
  // Captures every started byte and answers with tx_done resp_delay cycles later.
  initial begin
    tx.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx.tx_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) tx.tx_done = 1'b1;
      end
      if (tx.tx_start === 1'b1) begin
        got_q.push_back(tx.tx_data);
        resp_cnt = resp_delay;
      end
      if (o_done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_time(input logic mode, input logic [4:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic [6:0] cs);
    i_mode = mode; i_hour = h; i_min = m; i_sec = s; i_msec = cs;
  endtask

  task automatic pulse_send();
    @(negedge clk);
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for o_done at a negedge; returns 1 if seen within the budget.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_exp(input logic [119:0] frame);
    exp_q.delete();
    for (int i = 0; i < 15; i++) exp_q.push_back(frame[119 - 8*i -: 8]);
  endtask

  task automatic compare_bytes(input string name, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
      check($sformatf("%s_byte%0d", name, i), {24'h0, g}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  lat;
    int  d0;
    bit  seen;
    @(negedge clk);
    set_time(v.mode, v.hour, v.min, v.sec, v.msec);
    got_q.delete();
    d0 = done_cnt;
    @(negedge clk);
    i_send = 1'b1;
    @(negedge clk);
    i_send = 1'b0;
    if (v.chg_hour) i_hour = 5'd23;
    lat = 1;
    while (tx.tx_start !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, "_latency"}, lat, 2);
    wait_done(1000, seen);
    check({v.name, "_done_seen"}, {31'h0, seen}, 1);
    check({v.name, "_busy_in_fin"}, {31'h0, o_busy}, 0);
    wait_cycles(5);
    check({v.name, "_nbytes"}, got_q.size(), 15);
    check({v.name, "_done_count"}, done_cnt - d0, 1);
    load_exp(v.exp);
    compare_bytes(v.name, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    int d0;

    vecs[0] = '{"basic", 1'b0, 5'd13, 6'd5, 6'd9, 7'd42, 1'b0,
                120'h57_20_31_33_3A_30_35_3A_30_39_2E_34_32_0D_0A};
    vecs[1] = '{"snapshot", 1'b1, 5'd0, 6'd0, 6'd0, 7'd0, 1'b1,
                120'h53_20_30_30_3A_30_30_3A_30_30_2E_30_30_0D_0A};
    vecs[2] = '{"saturate", 1'b0, 5'd31, 6'd7, 6'd63, 7'd120, 1'b0,
                120'h57_20_32_33_3A_30_37_3A_35_39_2E_39_39_0D_0A};
    vecs[3] = '{"stop_mix", 1'b1, 5'd9, 6'd59, 6'd30, 7'd5, 1'b0,
                120'h53_20_30_39_3A_35_39_3A_33_30_2E_30_35_0D_0A};

    reset = 1'b0; i_send = 1'b0; i_auto = 1'b0;
    set_time(1'b0, 5'd0, 6'd0, 6'd0, 7'd0);
    wait_cycles(3);
    check("reset_tx_data",  {24'h0, tx.tx_data}, 0);
    check("reset_tx_start", {31'h0, tx.tx_start}, 0);
    check("reset_busy",     {31'h0, o_busy}, 0);
    check("reset_done",     {31'h0, o_done}, 0);
    check("reset_state",    {29'h0, dbg_state}, 0);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(3);

    // Table-driven single frames.
    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Queuing: extra requests during a frame yield exactly one more frame.
    @(negedge clk);
    set_time(1'b0, 5'd13, 6'd5, 6'd9, 7'd42);
    got_q.delete();
    d0 = done_cnt;
    pulse_send();
    wait_cycles(30);  pulse_send();
    wait_cycles(50);  pulse_send();
    wait_cycles(50);  pulse_send();
    wait_done(1000, seen);
    check("queue_first_done", {31'h0, seen}, 1);
    check("queue_fin_busy_low", {31'h0, o_busy}, 0);
    @(negedge clk);
    check("queue_busy_back", {31'h0, o_busy}, 1);
    check("queue_state_load", {29'h0, dbg_state}, 1);
    wait_done(1000, seen);
    check("queue_second_done", {31'h0, seen}, 1);
    wait_cycles(450);
    check("queue_nbytes", got_q.size(), 30);
    check("queue_done_count", done_cnt - d0, 2);
    load_exp(vecs[0].exp);
    compare_bytes("queue_f2", 15);

    // Auto mode: seconds 58 -> 59 -> 0 gives two frames.
    @(negedge clk);
    set_time(1'b0, 5'd1, 6'd2, 6'd58, 7'd3);
    wait_cycles(3);
    got_q.delete();
    d0 = done_cnt;
    i_auto = 1'b1;
    wait_cycles(10);
    i_sec = 6'd59;
    wait_cycles(400);
    i_sec = 6'd0;
    wait_cycles(400);
    check("auto_nbytes", got_q.size(), 30);
    check("auto_done_count", done_cnt - d0, 2);
    check("auto_f1_sec_tens", (got_q.size() > 9)  ? {24'h0, got_q[8]}  : 32'hFFFF, 32'h35);
    check("auto_f1_sec_ones", (got_q.size() > 9)  ? {24'h0, got_q[9]}  : 32'hFFFF, 32'h39);
    check("auto_f2_sec_tens", (got_q.size() > 24) ? {24'h0, got_q[23]} : 32'hFFFF, 32'h30);
    check("auto_f2_sec_ones", (got_q.size() > 24) ? {24'h0, got_q[24]} : 32'hFFFF, 32'h30);

    // Same stimulus with i_auto low: nothing is sent.
    i_auto = 1'b0;
    i_sec = 6'd58;
    wait_cycles(10);
    got_q.delete();
    d0 = done_cnt;
    i_sec = 6'd59;
    wait_cycles(400);
    i_sec = 6'd0;
    wait_cycles(400);
    check("noauto_nbytes", got_q.size(), 0);
    check("noauto_done_count", done_cnt - d0, 0);

    // Reset in the middle of a frame.
    @(negedge clk);
    set_time(1'b0, 5'd13, 6'd5, 6'd9, 7'd42);
    got_q.delete();
    pulse_send();
    for (int i = 0; i < 1000 && got_q.size() < 7; i++) @(negedge clk);
    check("midreset_reached_byte6", got_q.size(), 7);
    wait_cycles(3);
    #2 reset = 1'b0;
    #1;
    check("midreset_tx_data",  {24'h0, tx.tx_data}, 0);
    check("midreset_tx_start", {31'h0, tx.tx_start}, 0);
    check("midreset_busy",     {31'h0, o_busy}, 0);
    check("midreset_done",     {31'h0, o_done}, 0);
    @(negedge clk);
    reset = 1'b1;
    got_q.delete();
    d0 = done_cnt;
    wait_cycles(100);
    check("midreset_silent_bytes", got_q.size(), 0);
    check("midreset_silent_done", done_cnt - d0, 0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/time_uart_reporter.md
Name: time_uart_reporter

Overview:
- Transmit-side companion to the UART command inputs (go/stop, clear, up, down) that drive the watch/stopwatch top.
- Snapshots the currently displayed time and serialises it as a 15-byte ASCII frame to a byte-level UART transmitter.
- Frame format: tag, space, "HH:MM:SS.CC", CR, LF.
- Sits beside the display-select mux and the UART TX. It is triggered by an explicit request or by an automatic once-per-second report.

Parameters:
- TAG_WATCH, 8'h57, tag byte sent when i_mode=0 ('W').
- TAG_STOP, 8'h53, tag byte sent when i_mode=1 ('S').

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i_send  input  1  single-cycle report request.
- i_auto  input  1  level; while 1, a change in i_sec triggers a report.
- i_mode  input  1  source tag select: 0 = watch, 1 = stopwatch.
- i_msec  input  7  centiseconds, 0..99.
- i_sec  input  6  seconds, 0..59.
- i_min  input  6  minutes, 0..59.
- i_hour  input  5  hours, 0..23.
- tx_done  input  1  single-cycle pulse from the UART TX when a byte has finished.
- tx_data  output  8  byte to transmit.
- tx_start  output  1  single-cycle start pulse to the UART TX.
- o_busy  output  1  high from frame acceptance until the last tx_done.
- o_done  output  1  single-cycle pulse after the LF byte completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0: tx_data=8'h00, tx_start=0, o_busy=0, o_done=0.
  - Byte index=0, pending=0, state=IDLE, sec-history register=0.
  - Reset asserted mid-frame aborts the frame immediately. No further tx_start is issued, and the pending request is discarded.
- Trigger sources:
  - i_send=1 for one cycle.
  - i_auto=1 and i_sec differs from its value registered on the previous cycle.
  - The sec-history register updates every cycle regardless of i_auto.
  - A trigger in IDLE starts a frame. A trigger in any other state sets pending=1; pending is one deep, so extra triggers are dropped.
- State machine:
  - IDLE: on a trigger or pending=1, go to LOAD and clear pending.
  - LOAD: one cycle.
    - Snapshot i_mode, hour, min, sec, msec into internal registers; later input changes do not affect the frame.
    - Convert each field to two ASCII digits: tens=v/10 and ones=v%10, each plus 8'h30.
    - Out-of-range inputs saturate before conversion: msec>99 gives 99, sec/min>59 give 59, hour>23 gives 23.
    - Set o_busy=1 and index=0. Go to SEND.
  - SEND: one cycle.
    - tx_data = byte[index] and tx_start=1. Go to WAIT.
    - tx_data holds its value until the next SEND.
  - WAIT: wait for tx_done=1.
    - If index=14: go to FIN.
    - Otherwise increment index and go to SEND.
    - tx_done seen in any other state is ignored.
  - FIN: one cycle.
    - o_done=1 and o_busy=0.
    - Next state is LOAD if pending=1, else IDLE.
- Byte order, index 0..14:
  - 0: tag. 1: 8'h20. 2,3: hour digits. 4: 8'h3A.
  - 5,6: min digits. 7: 8'h3A. 8,9: sec digits. 10: 8'h2E.
  - 11,12: msec digits. 13: 8'h0D. 14: 8'h0A.
- Latency: the first tx_start occurs 2 cycles after the trigger cycle (trigger → LOAD → SEND).
- Simultaneous events:
  - i_send and an auto trigger in the same cycle count as one trigger.
  - A trigger arriving during FIN sets pending and is serviced directly (FIN → LOAD).
- Pulse discipline: tx_start is never high in two consecutive cycles, and is never high again before tx_done is received.

Test Plan:
- Basic frame: i_mode=0, hour=13, min=5, sec=9, msec=42, pulse i_send; bench returns tx_done 20 cycles after each tx_start → bytes 57 20 31 33 3A 30 35 3A 30 39 2E 34 32 0D 0A, then one o_done pulse; first tx_start exactly 2 cycles after i_send.
- Snapshot hold: i_mode=1, all fields 0; change i_hour to 23 one cycle after the trigger → frame is 53 20 30 30 3A 30 30 3A 30 30 2E 30 30 0D 0A.
- Queuing: pulse i_send three times during frame 1 → exactly two frames total; o_busy stays 0 for only the single FIN cycle between them.
- Auto mode: i_auto=1, i_sec steps 58→59→0 with gaps longer than one frame → two frames, with sec bytes "59" then "00"; with i_auto=0 the same stimulus produces no frame.
- Saturation: msec=7'd120, hour=5'd31 → msec digits 39 39 and hour digits 32 33.
- Reset mid-frame: assert reset during byte 6 → all outputs 0 asynchronously; after release there is no tx_start until a new i_send, which produces a full 15-byte frame starting with the tag.
